// File: rtl/regfile_dump_reader.sv
// Purpose : sequential register-file dump engine; on a start pulse it reads
//           registers 0..NUM_REGS-1 through one read port and streams each
//           word out on a valid/ready port, then pulses done.
// Latency : first beat valid 3 cycles after start is sampled; 3 cycles per
//           word with out_ready high, plus one DONE cycle.
// Backpressure: out_ready low holds the current beat stable in SEND; the
//           engine stalls there until the beat is accepted.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   clr_n      asynchronous active-low reset
//   start      request a full dump, only honoured in IDLE
//   rd_addr    register-file read address (index in ISSUE/CAPTURE, else 0)
//   rd_data    register-file read data (combinational or 1-cycle registered)
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_data   beat payload
//   out_addr   register address of the beat
//   out_last   final beat of the dump
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the final beat is accepted
//
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append one checksum
// beat (XOR of all dumped words, out_addr = 0, out_last = 1) after the last
// register. Without it, out_last marks register NUM_REGS-1.
//
// ADDR_W must be wide enough that 2**ADDR_W >= NUM_REGS.

module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4,
    S_CSUM    = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              xfer;
  logic              at_last;

  assign xfer    = out_valid && out_ready;
  assign at_last = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (at_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: index, captured beat and (optionally) checksum accumulator
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      idx_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      idx_q <= '0;
    end else if (state_q == S_SEND && xfer && !at_last) begin
      // The final beat always leaves SEND, so the index never wraps.
      idx_q <= idx_q + ADDR_W'(1);
    end
  end

  // rd_addr is already stable for the whole of ISSUE and CAPTURE, so
  // sampling at the end of CAPTURE covers both a combinational read and a
  // read port that registers the address once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data_q <= '0;
      addr_q <= '0;
    end else if (state_q == S_CAPTURE) begin
      data_q <= rd_data;
      addr_q <= idx_q;
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q;

  // Only register beats fold in; the checksum beat itself is not included.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      acc_q <= '0;
    end else if (state_q == S_SEND && xfer) begin
      acc_q <= acc_q ^ data_q;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Output logic. Every output decodes from state so a reset forces them
  // all to zero at once, without waiting for a clock edge.
  // ---------------------------------------------------------------------
  always_comb begin
    rd_addr   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    out_last  = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    case (state_q)
      S_ISSUE, S_CAPTURE: begin
        rd_addr = idx_q;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = data_q;
        out_addr  = addr_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last  = 1'b0;
`else
        out_last  = at_last;
`endif
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        out_addr  = '0;
        out_last  = 1'b1;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        rd_addr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a queue of expected beats is built from the
// register-file contents whenever a dump is started; a negedge monitor
// compares every visible beat against the head of that queue and pops it on
// acceptance, and the directed sequence pins latency, totals and checksums.
module tb_regfile_dump_reader;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr_n = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Expected-beat model
  logic [DATA_W-1:0] eq_data [$];
  logic [ADDR_W-1:0] eq_addr [$];
  logic              eq_last [$];

  int total = 0;
  int passed = 0;
  int done_cnt = 0;
  int beats_seen = 0;
  int busy_cycles = 0;
  int stall_cnt = 0;
  bit prev_last_acc = 1'b0;
  logic [DATA_W-1:0] first_data = '0;
  logic [DATA_W-1:0] last_data = '0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic build_expected();
    logic [DATA_W-1:0] x;
    x = '0;
    eq_data.delete();
    eq_addr.delete();
    eq_last.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      eq_addr.push_back(ADDR_W'(i));
      eq_data.push_back(regs[i]);
      eq_last.push_back(!CSUM && (i == NUM_REGS - 1));
      x ^= regs[i];
    end
    if (CSUM) begin
      eq_addr.push_back('0);
      eq_data.push_back(x);
      eq_last.push_back(1'b1);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!clr_n) begin
      prev_last_acc = 1'b0;
    end else begin
      if (!busy)
        chk("idle_outputs_zero", {out_valid, out_last, out_data, out_addr, rd_addr, done}, 64'd0);
      else
        busy_cycles++;
      if (done || prev_last_acc) chk("done_after_last_accept", done, prev_last_acc);
      if (done) begin
        done_cnt++;
        chk("queue_empty_at_done", eq_data.size(), 0);
      end
      prev_last_acc = 1'b0;
      if (out_valid) begin
        chk("beat_pending", eq_data.size() > 0, 1);
        if (eq_data.size() > 0) begin
          chk("beat_addr", out_addr, eq_addr[0]);
          chk("beat_data", out_data, eq_data[0]);
          chk("beat_last", out_last, eq_last[0]);
          if (out_ready) begin
            if (beats_seen == 0) first_data = out_data;
            beats_seen++;
            last_data = out_data;
            last_addr = out_addr;
            if (out_last) prev_last_acc = 1'b1;
            eq_data.pop_front();
            eq_addr.pop_front();
            eq_last.pop_front();
          end else begin
            stall_cnt++;
          end
        end
      end
    end
  end

  // Start a dump: start is sampled on the first rising edge; returns just
  // after that edge (the ISSUE cycle).
  task automatic kick();
    start = 1'b1;
    build_expected();
    beats_seen  = 0;
    busy_cycles = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_latency();
    int lat;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_valid_latency", lat, 3);
  endtask

  task automatic wait_done();
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt != d0, 1);
  endtask

  task automatic wait_beat(input int a);
    int n;
    n = 0;
    while (!(out_valid && out_addr == ADDR_W'(a)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_beat", out_valid && out_addr == ADDR_W'(a), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hA5A5_0000 + i;

    // Reset values
    clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_last, out_data, out_addr, rd_addr, busy, done}, 64'd0);
    clr_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_hold_busy", busy, 0);

    // Full dump without backpressure
    d0 = done_cnt;
    kick();
    check_latency();
    wait_done();
    chk("busy_cycles", busy_cycles, CSUM ? 98 : 97);
    chk("beats_total", beats_seen, CSUM ? 33 : 32);
    chk("first_beat_data", first_data, 32'hA5A5_0000);
    chk("last_beat_data", last_data, CSUM ? 32'h0 : 32'hA5A5_001F);
    chk("last_beat_addr", last_addr, CSUM ? 0 : 31);
    repeat (3) @(posedge clk);
    #1;
    chk("one_done_full", done_cnt - d0, 1);

    // Backpressure on beat 7
    stall_cnt = 0;
    kick();
    wait_beat(7);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stalled_beat7_valid", out_valid, 1);
    chk("stalled_beat7_data", out_data, 32'hA5A5_0007);
    out_ready = 1'b1;
    wait_done();
    chk("stall_cycles", stall_cnt, 5);
    chk("beats_after_stall", beats_seen, CSUM ? 33 : 32);

    // Start while busy
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    kick();
    wait_beat(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    chk("restart_ignored_busy", busy, 0);
    chk("restart_one_done", done_cnt - d0, 1);
    chk("restart_beats", beats_seen, CSUM ? 33 : 32);
    chk("restart_busy_cycles", busy_cycles, CSUM ? 98 : 97);

    // Reset during SEND of beat 15
    kick();
    wait_beat(15);
    d0 = done_cnt;
    clr_n = 1'b0;
    #1;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_busy", busy, 0);
    eq_data.delete();
    eq_addr.delete();
    eq_last.delete();
    repeat (3) @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_no_done", done_cnt - d0, 0);
    kick();
    check_latency();
    chk("midreset_restart_addr", out_addr, 0);
    wait_done();
    chk("midreset_restart_beats", beats_seen, CSUM ? 33 : 32);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // Checksum beat
    for (int i = 0; i < NUM_REGS; i++) regs[i] = i;
    repeat (2) @(posedge clk);
    #1;
    kick();
    wait_done();
    chk("csum_zero", last_data, 32'h0);
    chk("csum_beats", beats_seen, 33);
    regs[3] = 32'hFF;
    repeat (2) @(posedge clk);
    #1;
    kick();
    wait_done();
    chk("csum_fc", last_data, 32'hFC);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the processor register file. On a single `start` pulse it reads every register in ascending address order through one read port and streams each word out over a valid/ready handshake. It then pulses `done`. It sits beside the register file as the debug and scan-out path, consuming values that the write side has stored.

## Interface
- `NUM_REGS`, default 32: number of registers dumped, addresses 0..NUM_REGS-1.
- `ADDR_W`, default 5: register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- `DATA_W`, default 32: register data width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `clr_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a full dump; sampled only in IDLE.
- `rd_addr`  out  ADDR_W  register-file read address.
- `rd_data`  in  DATA_W  register-file read data.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  DATA_W  beat payload.
- `out_addr`  out  ADDR_W  register address of the beat.
- `out_last`  out  1  final beat of the dump.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, ISSUE, CAPTURE, SEND, DONE (plus CSUM when configured).
- IDLE: all outputs 0. When `start`=1, clear index to 0 and go to ISSUE.
- ISSUE: drive `rd_addr` = index, then go to CAPTURE.
  - `rd_addr` holds the index in ISSUE and CAPTURE and is 0 elsewhere.
- CAPTURE: keep `rd_addr`, register `rd_data` into `out_data` and the index into `out_addr`, then go to SEND.
  - This supports a combinational read or a one-cycle registered read.
- SEND:
  - `out_valid`=1.
  - `out_last`=1 only when index = NUM_REGS-1 and CSUM is not configured.
  - On `out_valid && out_ready`: if index = NUM_REGS-1, go to CSUM if configured, otherwise DONE. Else increment the index and go to ISSUE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored; there is no queuing and no restart.
- Index width is ADDR_W. The index never wraps, because the final beat always exits SEND.

## Timing
- Reset (`clr_n`=0, any time, asynchronous): state becomes IDLE, index 0, and all outputs 0 immediately.
  - A partial dump is abandoned and no `done` is produced.
  - Operation resumes on the first edge after `clr_n` rises.
- `start` sampled high at edge k:
  - ISSUE in cycle k+1.
  - CAPTURE in cycle k+2.
  - First `out_valid` in cycle k+3.
- With `out_ready` held at 1, each word costs 3 cycles. A dump is 3·NUM_REGS cycles plus 1 DONE cycle (plus 1 CSUM beat if configured).
- Handshake rules:
  - A beat transfers on a rising edge with `out_valid`=1 and `out_ready`=1.
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_addr` and `out_last` are held stable.
  - `out_valid` never drops before acceptance.
- `out_valid` is 0 in ISSUE and CAPTURE, so beats are never back-to-back.
- `busy` rises the cycle after `start` is sampled and falls the cycle after DONE.

## Configuration
- Macro: `REGFILE_DUMP_CHECKSUM_EN`.
- Defined:
  - An accumulator XORs every accepted data beat and clears on `start`.
  - After register NUM_REGS-1 is accepted, the CSUM state emits one extra beat: `out_data` = XOR of all NUM_REGS words, `out_addr`=0, `out_last`=1.
  - Acceptance of that beat goes to DONE.
- Undefined:
  - No accumulator and no CSUM state.
  - `out_last` marks register NUM_REGS-1.
  - NUM_REGS beats in total.

## Test plan
- Reset values:
  - Stimulus: hold `clr_n`=0 for 3 cycles, then release.
  - Response: all outputs 0 and `busy`=0. `start`=0 keeps the block in IDLE indefinitely.
- Full dump, no backpressure:
  - Stimulus: model regfile reg[i]=32'hA5A5_0000+i, `out_ready`=1, 1-cycle `start`.
  - Response: 32 beats with `out_addr` 0..31 and `out_data` 32'hA5A5_0000..32'hA5A5_001F in order.
  - First `out_valid` 3 cycles after `start`; `out_last` only on address 31; `done` 1 cycle after the last accept; total 97 cycles.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles on beat 7.
  - Response: `out_valid`, `out_data`=32'hA5A5_0007 and `out_addr`=7 are stable for all 5 cycles. Exactly one transfer of beat 7 occurs and no beat is skipped.
- Start while busy:
  - Stimulus: pulse `start` again during beat 10.
  - Response: the dump continues unchanged, exactly 32 beats, one `done`.
- Mid-dump reset:
  - Stimulus: assert `clr_n`=0 during SEND of beat 15.
  - Response: `out_valid` and `busy` drop immediately and no `done` follows. A new `start` restarts at address 0.
- With `REGFILE_DUMP_CHECKSUM_EN`:
  - Stimulus: set reg[i]=i.
  - Response: 33 beats; beat 33 has `out_data` = XOR of 0..31 = 0, `out_addr`=0, `out_last`=1.
  - Then set reg[3]=32'hFF and re-dump: checksum = 32'hFC (32'hFF ^ 3).
